// File: rtl/wb_mst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_mst_arbiter
// Description : Arbitrates NM Wishbone masters onto one shared slave bus.
//               Round-robin or fixed-priority selection. The owner keeps the
//               bus while its cyc is high. A stalled-strobe watchdog can end
//               the cycle with a single-cycle bus error.
// Ports       : wb_clk_i  - clock, rising edge
//               rst_n     - synchronous active-low reset
//               m_*_i     - per-master cyc/stb/we/sel/adr/dat, slice k per master
//               m_ack_o   - per-master acknowledge (owner only)
//               m_err_o   - per-master timeout error (owner only)
//               m_dat_o   - slave read data broadcast to all masters
//               s_*_o     - shared slave request bus
//               s_ack_i   - slave acknowledge
//               s_dat_i   - slave read data
//               grant_o   - one-hot current owner, zero when idle
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mst_arbiter #(
    parameter int NM        = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_n,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [DW-1:0]        m_dat_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    input  logic                 s_ack_i,
    input  logic [DW-1:0]        s_dat_i,
    output logic [NM-1:0]        grant_o
);

    localparam int          c_SW      = DW / 8;
    localparam int          c_IW      = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN  = 2'd1;
    localparam logic [1:0] c_ERR  = 2'd2;

    logic [1:0]      r_state;
    logic [NM-1:0]   r_grant;
    logic [c_IW-1:0] r_owner;
    logic [c_IW-1:0] r_rr_ptr;
    logic [15:0]     r_cnt;

    logic [c_IW:0]   w_cand;
    logic [c_IW-1:0] w_win;
    logic            w_found;

    logic            w_cyc;
    logic            w_stb;
    logic            w_we;
    logic [c_SW-1:0] w_sel;
    logic [AW-1:0]   w_adr;
    logic [DW-1:0]   w_dat;

    logic            w_own;
    logic [15:0]     w_cnt_inc;
    logic            w_timeout;

    // Winner search. Fixed mode scans from 0; round-robin scans from the
    // pointer with wrap. The candidate carries one extra bit so ptr+i
    // cannot overflow before the wrap subtraction.
    always_comb begin
        w_cand  = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (PRIO_MODE != 0) begin
                w_cand = (c_IW+1)'(i);
            end else begin
                w_cand = {1'b0, r_rr_ptr} + (c_IW+1)'(i);
            end
            if (w_cand >= (c_IW+1)'(NM)) begin
                w_cand = w_cand - (c_IW+1)'(NM);
            end
            if (!w_found && m_cyc_i[w_cand[c_IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[c_IW-1:0];
            end
        end
    end

    // Owner slice mux.
    always_comb begin
        w_cyc = 1'b0;
        w_stb = 1'b0;
        w_we  = 1'b0;
        w_sel = '0;
        w_adr = '0;
        w_dat = '0;
        for (int k = 0; k < NM; k++) begin
            if (r_owner == c_IW'(k)) begin
                w_cyc = m_cyc_i[k];
                w_stb = m_stb_i[k];
                w_we  = m_we_i[k];
                w_sel = m_sel_i[k*c_SW +: c_SW];
                w_adr = m_adr_i[k*AW +: AW];
                w_dat = m_dat_i[k*DW +: DW];
            end
        end
    end

    // Reset gates the outputs immediately so an aborted transfer never
    // hands the former owner an ack or err.
    assign w_own = rst_n && (r_state == c_OWN);

    assign s_cyc_o = w_own & w_cyc;
    assign s_stb_o = w_own & w_stb;
    assign s_we_o  = w_own & w_we;
    assign s_sel_o = w_own ? w_sel : '0;
    assign s_adr_o = w_own ? w_adr : '0;
    assign s_dat_o = w_own ? w_dat : '0;

    assign m_ack_o = (w_own && s_ack_i) ? r_grant : '0;
    assign m_err_o = (rst_n && (r_state == c_ERR)) ? r_grant : '0;
    assign m_dat_o = s_dat_i;
    assign grant_o = r_grant;

    // An ack in the same cycle the count would hit the limit wins, because
    // the timeout only fires on a stalled (unacked) strobe.
    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_timeout = (TIMEOUT != 0) && w_stb && !s_ack_i && (w_cnt_inc == c_TIMEOUT);

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (w_found) begin
                        r_state  <= c_OWN;
                        r_owner  <= w_win;
                        r_grant  <= {{(NM-1){1'b0}}, 1'b1} << w_win;
                        r_rr_ptr <= (w_win == c_IW'(NM-1)) ? '0 : w_win + 1'b1;
                    end
                end
                c_OWN: begin
                    if (!w_cyc) begin
                        r_state <= c_IDLE;
                        r_grant <= '0;
                        r_cnt   <= '0;
                    end else if (s_ack_i) begin
                        r_cnt <= '0;
                    end else if (w_stb) begin
                        r_cnt <= w_cnt_inc;
                        if (w_timeout) begin
                            r_state <= c_ERR;
                        end
                    end
                end
                c_ERR: begin
                    r_state <= c_IDLE;
                    r_grant <= '0;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_grant <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/wb_mst_arbiter.md
WB_MST_ARBITER -- requirements
Module: wb_mst_arbiter

Interface
REQ-001 SHALL have parameter NM, default 4: number of Wishbone masters (2..8).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width; select width is DW/8.
REQ-004 SHALL have parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-005 SHALL have parameter TIMEOUT, default 255: cycles without ack before a bus error (0 = disabled; max 65535).
REQ-006 SHALL use one clock and a synchronous, active-low reset.
REQ-007 SHALL have port wb_clk_i  in  1  clock, all logic on rising edge.
REQ-008 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-009 SHALL have port m_cyc_i  in  NM  per-master cycle.
REQ-010 SHALL have port m_stb_i  in  NM  per-master strobe.
REQ-011 SHALL have port m_we_i  in  NM  per-master write enable.
REQ-012 SHALL have port m_sel_i  in  NM*DW/8  per-master byte selects; master k at slice [k*DW/8 +: DW/8].
REQ-013 SHALL have port m_adr_i  in  NM*AW  per-master address, same slicing.
REQ-014 SHALL have port m_dat_i  in  NM*DW  per-master write data, same slicing.
REQ-015 SHALL have port m_ack_o  out  NM  per-master acknowledge.
REQ-016 SHALL have port m_err_o  out  NM  per-master timeout error.
REQ-017 SHALL have port m_dat_o  out  DW  read data, broadcast to all masters.
REQ-018 SHALL have ports s_cyc_o, s_stb_o, s_we_o  out  1 each; s_sel_o  out  DW/8; s_adr_o  out  AW; s_dat_o  out  DW: shared slave bus.
REQ-019 SHALL have ports s_ack_i  in  1 and s_dat_i  in  DW: slave response.
REQ-020 SHALL have port grant_o  out  NM  one-hot current owner (all-zero when idle).

Function
REQ-021 SHALL implement states IDLE, OWN, ERR.
REQ-022 IDLE: when any m_cyc_i bit is high, SHALL select a winner, load grant_o, and enter OWN on the next edge; grant latency is 1 cycle.
REQ-023 Fixed mode SHALL pick the lowest requesting index.
REQ-024 Round-robin mode SHALL search from pointer rr_ptr upward with wrap; on grant to k, rr_ptr SHALL become (k+1) mod NM, wrapping NM-1 -> 0.
REQ-025 OWN: s_cyc_o/s_stb_o SHALL equal the owner's cyc/stb; s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL equal the owner's slices, combinationally.
REQ-026 Outside OWN, s_cyc_o and s_stb_o SHALL be 0; the other slave outputs SHALL be don't-care and are driven 0.
REQ-027 m_ack_o[owner] SHALL equal s_ack_i in OWN; non-owner ack/err SHALL be 0 always; m_dat_o SHALL equal s_dat_i.
REQ-028 The owner SHALL keep the bus while its m_cyc_i is high, across any number of back-to-back strobes (no preemption).
REQ-029 When the owner drops m_cyc_i, the block SHALL return to IDLE on that edge; the next grant SHALL appear one cycle later, giving a minimum 1 idle cycle between owners.
REQ-030 Timeout: a 16-bit counter SHALL clear on entering OWN and on every s_ack_i, and SHALL increment each OWN cycle with s_stb_o=1 and s_ack_i=0.
REQ-031 When the counter reaches TIMEOUT (nonzero), the block SHALL enter ERR.
REQ-032 ERR (exactly 1 cycle): m_err_o[owner]=1, s_cyc_o=s_stb_o=0, grant_o held; the next state SHALL be IDLE.
REQ-033 An s_ack_i arriving in the same cycle the count reaches TIMEOUT SHALL win: ack delivered, no error.
REQ-034 Requests with m_stb_i=1 and m_cyc_i=0 SHALL be ignored.

Reset
REQ-035 While rst_n=0 at an edge: state=IDLE, grant_o=0, rr_ptr=0, counter=0, all m_ack_o/m_err_o=0, s_cyc_o=s_stb_o=0.
REQ-036 Reset asserted mid-transfer SHALL abort it with no ack or err to the former owner.

Verification
REQ-037 NM=4, RR: masters 0..3 hold cyc continuously, each releasing after 1 acked transfer -> grant order 0,1,2,3,0, with exactly 1 idle cycle between grants.
REQ-038 PRIO_MODE=1: masters 1 and 3 request together -> master 1 is granted; master 3 is granted after master 1 drops cyc.
REQ-039 Owner 2 issues 3 back-to-back strobes while master 0 requests -> all 3 acks go to master 2, and m_ack_o[0]=0 throughout.
REQ-040 TIMEOUT=8, slave never acks -> m_err_o[owner]=1 for exactly 1 cycle, 8 stalled cycles after the first strobe; then IDLE.
REQ-041 TIMEOUT=8, ack on the 8th stalled cycle -> ack delivered and m_err_o stays 0.
REQ-042 rst_n=0 during OWN with a pending strobe -> next cycle grant_o=0 and s_cyc_o=0; after release, master 0 is first in the round-robin order.
